// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle main controller.
//   state_t : controller state encoding (4 bits, visible on state_o)
//   ctrl_t  : control word produced by the output decoder
//   OP_*    : opcode encodings (4-bit)
//   SRCB_* / ALUOP_* / PCSRC_* : datapath select encodings
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the TRAP state and the illegal flag.
package mc_ctrl_fsm_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OPC_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OPC_W-1:0] OP_LW    = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SW    = 4'b1001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_CBZ   = 4'b1011;
    localparam logic [OPC_W-1:0] OP_B     = 4'b1100;

    localparam logic [SEL_W-1:0] SRCB_REGB   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`ifdef MC_ILLEGAL_TRAP_EN
        , S_TRAP = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic             memreq;
        logic             memwrite;
        logic             iord;
        logic             irwrite;
        logic             regwrite;
        logic             regdst;
        logic             memtoreg;
        logic             alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic [SEL_W-1:0] aluop;
        logic [SEL_W-1:0] pcsrc;
        logic             pcen;
        logic             instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
        logic             illegal;
`endif
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle.
//   master : controller side (drives controls, receives op/zero/memrdy)
//   slave  : datapath side
// illegal is present only when MC_ILLEGAL_TRAP_EN is defined.
interface mc_ctrl_fsm_if #(
    parameter int unsigned OP_W = 4
);
    logic [OP_W-1:0]                           op;
    logic                                      zero;
    logic                                      memrdy;
    logic                                      memreq;
    logic                                      memwrite;
    logic                                      iord;
    logic                                      irwrite;
    logic                                      regwrite;
    logic                                      regdst;
    logic                                      memtoreg;
    logic                                      alusrca;
    logic [mc_ctrl_fsm_pkg::SEL_W-1:0]         alusrcb;
    logic [mc_ctrl_fsm_pkg::SEL_W-1:0]         aluop;
    logic [mc_ctrl_fsm_pkg::SEL_W-1:0]         pcsrc;
    logic                                      pcen;
    logic                                      instr_done;
    logic [mc_ctrl_fsm_pkg::STATE_W-1:0]       state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic                                      illegal;
`endif

    modport master (
        input  op, zero, memrdy,
        output memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, state_o
`ifdef MC_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output op, zero, memrdy,
        input  memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen, instr_done, state_o
`ifdef MC_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/mc_ctrl_fsm_outdec.sv
// Output decoder: current state (+memrdy, zero) -> control word.
//   state      : current controller state
//   reset      : forces all strobes low while asserted
//   memrdy     : memory handshake completion
//   zero       : ALU zero flag for CBZ
//   decode_nop : DECODE holds an opcode that completes as a NOP
//   ctrl       : decoded control word (combinational)
// MC_ILLEGAL_TRAP_EN adds the TRAP decode and the illegal flag.
module mc_ctrl_fsm_outdec
    import mc_ctrl_fsm_pkg::*;
(
    input  state_t state,
    input  logic   reset,
    input  logic   memrdy,
    input  logic   zero,
    input  logic   decode_nop,
    output ctrl_t  ctrl
);

    logic pcwrite;
    logic branch;

    // Moore decode; handshake-qualified strobes only fire on memrdy.
    always_comb begin
        ctrl    = '0;
        pcwrite = 1'b0;
        branch  = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.memreq  = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = memrdy;
                pcwrite      = memrdy;
            end
            S_DECODE: begin
                ctrl.alusrcb    = SRCB_IMMSH2;
                ctrl.instr_done = decode_nop;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memreq = 1'b1;
                ctrl.iord   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memreq     = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = memrdy;
            end
            S_MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                branch          = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                pcwrite         = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
`endif
            default: begin
            end
        endcase

        ctrl.pcen = pcwrite | (branch & zero);

        // State is already FETCH during reset; only the strobes need masking.
        if (reset) begin
            ctrl.memreq     = 1'b0;
            ctrl.memwrite   = 1'b0;
            ctrl.irwrite    = 1'b0;
            ctrl.regwrite   = 1'b0;
            ctrl.pcen       = 1'b0;
            ctrl.instr_done = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
            ctrl.illegal    = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: Moore FSM sequencing a shared-ALU/shared-memory
// datapath, with a memory req/rdy handshake that can stall fetch and data access.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : mc_ctrl_fsm_if.master (op/zero/memrdy in; selects, strobes, state_o out)
// Parameter OP_W: opcode width.
// MC_ILLEGAL_TRAP_EN: unknown opcodes enter an absorbing TRAP state and raise illegal;
// otherwise they complete as a NOP.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OP_W = OPC_W
) (
    input  logic              clk,
    input  logic              reset,
    mc_ctrl_fsm_if.master     bus
);

    localparam logic [OP_W-1:0] C_RTYPE = OP_W'(OP_RTYPE);
    localparam logic [OP_W-1:0] C_LW    = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] C_SW    = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] C_ADDI  = OP_W'(OP_ADDI);
    localparam logic [OP_W-1:0] C_CBZ   = OP_W'(OP_CBZ);
    localparam logic [OP_W-1:0] C_B     = OP_W'(OP_B);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   is_rtype, is_lw, is_sw, is_addi, is_cbz, is_b;
    logic   decode_nop;

    assign is_rtype = (bus.op == C_RTYPE);
    assign is_lw    = (bus.op == C_LW);
    assign is_sw    = (bus.op == C_SW);
    assign is_addi  = (bus.op == C_ADDI);
    assign is_cbz   = (bus.op == C_CBZ);
    assign is_b     = (bus.op == C_B);

`ifdef MC_ILLEGAL_TRAP_EN
    assign decode_nop = 1'b0;
`else
    assign decode_nop = ~(is_rtype | is_lw | is_sw | is_addi | is_cbz | is_b);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.memrdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_lw || is_sw)  state_d = S_MEMADR;
                else if (is_rtype)   state_d = S_EXEC;
                else if (is_addi)    state_d = S_ADDIEX;
                else if (is_cbz)     state_d = S_BRANCH;
                else if (is_b)       state_d = S_JUMP;
                else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                if (is_sw)      state_d = S_MEMWR;
                else if (is_lw) state_d = S_MEMRD;
                else            state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (bus.memrdy) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (bus.memrdy) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_fsm_outdec u_outdec (
        .state      (state_q),
        .reset      (reset),
        .memrdy     (bus.memrdy),
        .zero       (bus.zero),
        .decode_nop (decode_nop),
        .ctrl       (ctrl)
    );

    assign bus.memreq     = ctrl.memreq;
    assign bus.memwrite   = ctrl.memwrite;
    assign bus.iord       = ctrl.iord;
    assign bus.irwrite    = ctrl.irwrite;
    assign bus.regwrite   = ctrl.regwrite;
    assign bus.regdst     = ctrl.regdst;
    assign bus.memtoreg   = ctrl.memtoreg;
    assign bus.alusrca    = ctrl.alusrca;
    assign bus.alusrcb    = ctrl.alusrcb;
    assign bus.aluop      = ctrl.aluop;
    assign bus.pcsrc      = ctrl.pcsrc;
    assign bus.pcen       = ctrl.pcen;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.state_o    = STATE_W'(state_q);
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal    = ctrl.illegal;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle state and strobe vectors with
// hand-computed expectations. Strobe vector bit order:
// {memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg, pcen, instr_done}
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.OP_W(4)) bif ();

    mc_ctrl_fsm #(.OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    logic [8:0] strb;
    assign strb = {bif.memreq, bif.memwrite, bif.iord, bif.irwrite, bif.regwrite,
                   bif.regdst, bif.memtoreg, bif.pcen, bif.instr_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply handshake inputs for this cycle, settle, compare state and strobes.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input int st, input logic [8:0] es);
        bif.memrdy = rdy;
        bif.zero   = z;
        #1;
        chk({tag, ".state"}, 32'(bif.state_o), 32'(st));
        chk({tag, ".strb"},  32'(strb), 32'(es));
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        bif.op     = 4'b1000;
        bif.memrdy = 1'b0;
        bif.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: strobes masked even with memrdy high, selects at FETCH values.
        cyc("rst", 1'b1, 1'b0, 0, 9'h000);
        chk("rst.alusrcb", 32'(bif.alusrcb), 32'd1);
        chk("rst.aluop",   32'(bif.aluop),   32'd0);
        reset = 1'b0;

        // LW with memrdy=1: five cycles.
        cyc("lw.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("lw.decode", 1'b1, 1'b0, 1, 9'h000);
        chk("lw.decode.alusrcb", 32'(bif.alusrcb), 32'd3);
        next(); cyc("lw.memadr", 1'b1, 1'b0, 2, 9'h000);
        chk("lw.memadr.alusrca", 32'(bif.alusrca), 32'd1);
        chk("lw.memadr.alusrcb", 32'(bif.alusrcb), 32'd2);
        next(); cyc("lw.memrd", 1'b1, 1'b0, 3, 9'h140);
        next(); cyc("lw.memwb", 1'b1, 1'b0, 4, 9'h015);

        // SW with three stalled MEMWR cycles.
        bif.op = 4'b1001;
        next(); cyc("sw.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("sw.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("sw.memadr", 1'b1, 1'b0, 2, 9'h000);
        for (int i = 0; i < 3; i++) begin
            next(); cyc("sw.memwr_stall", 1'b0, 1'b0, 5, 9'h1C0);
        end
        next(); cyc("sw.memwr_done", 1'b1, 1'b0, 5, 9'h1C1);

        // CBZ taken.
        bif.op = 4'b1011;
        next(); cyc("cbz1.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("cbz1.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("cbz1.branch", 1'b1, 1'b1, 8, 9'h003);
        chk("cbz1.pcsrc", 32'(bif.pcsrc), 32'd1);
        chk("cbz1.aluop", 32'(bif.aluop), 32'd1);

        // CBZ not taken.
        next(); cyc("cbz0.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("cbz0.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("cbz0.branch", 1'b1, 1'b0, 8, 9'h001);

        // RTYPE with two stalled FETCH cycles.
        bif.op = 4'b0000;
        next(); cyc("rt.fetch_stall0", 1'b0, 1'b0, 0, 9'h100);
        next(); cyc("rt.fetch_stall1", 1'b0, 1'b0, 0, 9'h100);
        next(); cyc("rt.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("rt.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("rt.exec", 1'b1, 1'b0, 6, 9'h000);
        chk("rt.exec.aluop", 32'(bif.aluop), 32'd2);
        next(); cyc("rt.aluwb", 1'b1, 1'b0, 7, 9'h019);

        // ADDI.
        bif.op = 4'b1010;
        next(); cyc("addi.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("addi.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("addi.ex", 1'b1, 1'b0, 9, 9'h000);
        next(); cyc("addi.wb", 1'b1, 1'b0, 10, 9'h011);

        // B.
        bif.op = 4'b1100;
        next(); cyc("b.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("b.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("b.jump", 1'b1, 1'b0, 11, 9'h003);
        chk("b.pcsrc", 32'(bif.pcsrc), 32'd2);

        // Asynchronous reset in the middle of a stalled MEMWR.
        bif.op = 4'b1001;
        next(); cyc("rsw.fetch", 1'b1, 1'b0, 0, 9'h122);
        next(); cyc("rsw.decode", 1'b1, 1'b0, 1, 9'h000);
        next(); cyc("rsw.memadr", 1'b1, 1'b0, 2, 9'h000);
        next(); cyc("rsw.memwr", 1'b0, 1'b0, 5, 9'h1C0);
        reset = 1'b1;
        cyc("rsw.async", 1'b0, 1'b0, 0, 9'h000);
        reset = 1'b0;
        cyc("rsw.release", 1'b0, 1'b0, 0, 9'h100);

        // Unknown opcode 0111.
        bif.op = 4'b0111;
        next(); cyc("ill.fetch", 1'b1, 1'b0, 0, 9'h122);
`ifdef MC_ILLEGAL_TRAP_EN
        next(); cyc("ill.decode", 1'b1, 1'b0, 1, 9'h000);
        chk("ill.decode.illegal", 32'(bif.illegal), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next(); cyc("ill.trap", 1'b1, 1'b0, 12, 9'h000);
            chk("ill.trap.illegal", 32'(bif.illegal), 32'd1);
        end
        reset = 1'b1;
        cyc("ill.rst", 1'b1, 1'b0, 0, 9'h000);
        chk("ill.rst.illegal", 32'(bif.illegal), 32'd0);
        reset = 1'b0;
        next(); cyc("ill.after", 1'b1, 1'b0, 1, 9'h000);
`else
        next(); cyc("nop.decode", 1'b1, 1'b0, 1, 9'h001);
        next(); cyc("nop.fetch", 1'b1, 1'b0, 0, 9'h122);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
